beam_trigger_gen: RTL and testbench
===================================

Name: beam_trigger_gen

Overview:
- Consumes the per-beam trigger vector from the beam alignment/threshold stage and turns it into global trigger events.
- Applies a per-beam mask and a programmable holdoff, and ORs together all beams firing within the holdoff window.
- Each event is timestamped and handed downstream as a single-entry record over a valid/ready handshake.
- Triggers that arrive while the record slot is occupied are dropped and counted.

Parameters:
- NBEAMS, 46, width of the trigger/mask/pattern vectors.
- HOLDOFF_BITS, 16, width of the holdoff length input.
- TS_BITS, 32, width of the free-running timestamp counter.
- DROP_BITS, 16, width of the saturating dropped-trigger counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- trigger_i  in  NBEAMS  per-beam trigger bits from upstream, sampled every clk_i.
- mask_i  in  NBEAMS  1 = beam disabled; applied live every cycle.
- holdoff_i  in  HOLDOFF_BITS  holdoff length H in cycles; latched at trigger acceptance.
- cnt_clr_i  in  1  synchronous clear of drop_count_o.
- trig_o  out  1  one-cycle global trigger pulse.
- event_valid_o  out  1  record slot holds a valid event.
- event_ready_i  in  1  downstream accepts the record when valid and ready are both high.
- event_beams_o  out  NBEAMS  accumulated beam pattern of the event.
- event_ts_o  out  TS_BITS  timestamp captured at trigger acceptance.
- drop_count_o  out  DROP_BITS  saturating count of rejected triggers.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE.
  - trig_o, event_valid_o, event_beams_o, event_ts_o and drop_count_o all go to 0.
  - Timestamp counter goes to 0.
- Timestamp counter: increments by 1 every cycle and wraps modulo 2^TS_BITS.
- Masking: hit = trigger_i & ~mask_i; any_hit = |hit.
- Slot free: slot_free = ~event_valid_o | event_ready_i.
- FSM state IDLE, on cycle T with any_hit:
  - If slot_free: accept the trigger.
    - trig_o = 1 at T+1.
    - Pattern register <= hit.
    - Timestamp register <= counter value at T.
    - Hold counter <= holdoff_i.
    - If holdoff_i == 0, the record is written directly: event_valid_o = 1 at T+1 and the FSM stays in IDLE. Otherwise go to ACCUM.
  - If not slot_free: drop the trigger. drop_count_o increments (saturates at all-ones). trig_o stays 0.
- FSM state ACCUM (cycles T+1 .. T+H):
  - Each cycle: pattern |= hit.
  - Hold counter decrements by 1 each cycle. No trig_o, no drop counting.
  - On the cycle the counter reaches 1: the record is written (event_beams_o = final pattern, event_ts_o = latched timestamp), event_valid_o = 1 at T+H+1, FSM returns to IDLE.
  - Earliest next acceptance is at cycle T+H+1.
  - The slot is guaranteed empty here, because acceptance required slot_free and only this FSM writes the slot.
- Handshake:
  - event_valid_o stays high, and the record stays stable, until a cycle with event_ready_i high; it clears on the following edge.
  - A same-cycle handshake and new record write is legal: the new record wins and event_valid_o stays 1.
- Counter clear: cnt_clr_i zeroes drop_count_o. A drop in the same cycle as cnt_clr_i yields drop_count_o = 1.
- Masking is live: a mask change during ACCUM affects only subsequent cycles. A fully masked trigger is ignored entirely, with no drop counted.
- holdoff_i changes during ACCUM have no effect on the current window.
- Reset mid-ACCUM or with a pending record discards that record; no output glitches beyond the reset values.

Decomposition:
- Package beam_trig_pkg holds:
  - NBEAMS default localparam;
  - typedef enum {IDLE, ACCUM} trig_state_t;
  - typedef struct packed {beams, ts} beam_event_t, used for the record slot.
- One natural sub-module: sat_counter (parameterised width, inc, clr), used for drop_count_o.

Test Plan:
- Reset, then trigger_i = 46'h1 at T with mask 0 and H = 4 -> trig_o pulses at T+1 only; event_valid_o rises at T+5 with event_beams_o = 46'h1 and event_ts_o = counter at T.
- During ACCUM, drive bit 3 at T+2 and bit 45 at T+4 (H = 4) -> event_beams_o = bits 0, 3 and 45 set; exactly one trig_o pulse.
- mask_i = 46'h2, trigger_i = 46'h2 -> no trig_o, no event, drop_count_o stays 0.
- Hold event_ready_i = 0 after the first event, then apply 3 more triggers -> drop_count_o = 3 and the original record is unchanged. Raise event_ready_i together with a new trigger -> trigger accepted, no new drop.
- H = 0 with back-to-back triggers on consecutive cycles and ready held high -> trig_o high on each following cycle and one record per trigger; then assert cnt_clr_i -> drop_count_o = 0.
- Assert rst_ni low mid-ACCUM (asynchronously, off-edge) -> all outputs go to 0 immediately; after release, the next trigger produces a normal event.

Source files
------------

// File: rtl/beam_trig_pkg.sv
// beam_trig_pkg: shared types and default widths for the beam trigger generator.
package beam_trig_pkg;
    localparam int NBEAMS_DEFAULT  = 46;
    localparam int TS_BITS_DEFAULT = 32;

    typedef enum logic {IDLE, ACCUM} trig_state_t;

    typedef struct packed {
        logic [NBEAMS_DEFAULT-1:0]  beams;
        logic [TS_BITS_DEFAULT-1:0] ts;
    } beam_event_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear; a clear coinciding with an increment yields 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= W'(inc);
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/beam_trigger_gen.sv
// beam_trigger_gen: masks per-beam triggers, ORs beams over a holdoff window and emits
// timestamped single-entry event records over valid/ready, counting triggers dropped on a full slot.
module beam_trigger_gen
    import beam_trig_pkg::*;
#(
    parameter int NBEAMS       = NBEAMS_DEFAULT,
    parameter int HOLDOFF_BITS = 16,
    parameter int TS_BITS      = TS_BITS_DEFAULT,
    parameter int DROP_BITS    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NBEAMS-1:0]       trigger_i,
    input  logic [NBEAMS-1:0]       mask_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    cnt_clr_i,
    output logic                    trig_o,
    output logic                    event_valid_o,
    input  logic                    event_ready_i,
    output logic [NBEAMS-1:0]       event_beams_o,
    output logic [TS_BITS-1:0]      event_ts_o,
    output logic [DROP_BITS-1:0]    drop_count_o
);
    trig_state_t             state, next_state;
    beam_event_t             slot;
    logic [TS_BITS-1:0]      ts_cnt, ts_lat, wr_ts;
    logic [NBEAMS-1:0]       hit, pattern, wr_beams;
    logic [HOLDOFF_BITS-1:0] hold;
    logic                    any_hit, slot_free, accept, drop, write, last;

    assign hit       = trigger_i & ~mask_i;
    assign any_hit   = |hit;
    assign slot_free = ~event_valid_o | event_ready_i;
    assign last      = hold == HOLDOFF_BITS'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        accept     = state == IDLE && any_hit && slot_free;
        drop       = state == IDLE && any_hit && !slot_free;
        write      = state == ACCUM ? last : accept && holdoff_i == '0;
        wr_beams   = state == ACCUM ? pattern | hit : hit;
        wr_ts      = state == ACCUM ? ts_lat : ts_cnt;
        next_state = state == ACCUM ? (last ? IDLE : ACCUM)
                                    : (accept && holdoff_i != '0 ? ACCUM : IDLE);
    end

    // The ACCUM write never collides with a pending record: acceptance required a free slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt        <= '0;
            ts_lat        <= '0;
            pattern       <= '0;
            hold          <= '0;
            trig_o        <= 1'b0;
            event_valid_o <= 1'b0;
            slot          <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            trig_o <= accept;
            if (accept) begin
                pattern <= hit;
                ts_lat  <= ts_cnt;
                hold    <= holdoff_i;
            end else if (state == ACCUM) begin
                pattern <= pattern | hit;
                hold    <= hold - 1'b1;
            end
            if (write) begin
                slot          <= '{beams: wr_beams, ts: wr_ts};
                event_valid_o <= 1'b1;
            end else if (event_ready_i) begin
                event_valid_o <= 1'b0;
            end
        end
    end

    assign event_beams_o = slot.beams;
    assign event_ts_o    = slot.ts;

    sat_counter #(.W(DROP_BITS)) u_drop_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (drop),
        .clr   (cnt_clr_i),
        .count (drop_count_o)
    );
endmodule

// File: tb/tb_beam_trigger_gen.sv
// tb_beam_trigger_gen: directed self-checking bench for beam_trigger_gen.
module tb_beam_trigger_gen;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [45:0] trigger_i;
    logic [45:0] mask_i;
    logic [15:0] holdoff_i;
    logic        cnt_clr_i;
    logic        trig_o;
    logic        event_valid_o;
    logic        event_ready_i;
    logic [45:0] event_beams_o;
    logic [31:0] event_ts_o;
    logic [15:0] drop_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ts_model = 0;
    logic [31:0] ts_exp;
    logic [45:0] beams_exp;

    beam_trigger_gen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .trigger_i     (trigger_i),
        .mask_i        (mask_i),
        .holdoff_i     (holdoff_i),
        .cnt_clr_i     (cnt_clr_i),
        .trig_o        (trig_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_beams_o (event_beams_o),
        .event_ts_o    (event_ts_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs applied before a step are sampled at its edge; outputs are read 1ns later.
    task automatic step;
        @(posedge clk_i);
        ts_model++;
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; trigger_i = '0; mask_i = '0; holdoff_i = '0;
        cnt_clr_i = 1'b0; event_ready_i = 1'b0;
        step; step;
        rst_ni = 1'b1; ts_model = 0;
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %0b want 0", trig_o); end
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", event_valid_o); end
        n_checks++; if (event_beams_o !== '0) begin n_fail++; $display("FAIL reset_beams: got %h want 0", event_beams_o); end
        n_checks++; if (event_ts_o !== '0) begin n_fail++; $display("FAIL reset_ts: got %h want 0", event_ts_o); end
        n_checks++; if (drop_count_o !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count_o); end
    endtask

    task automatic test_single;
        step; step;
        holdoff_i = 16'd4; trigger_i = 46'h1; ts_exp = ts_model;
        step;
        trigger_i = '0;
        n_checks++; if (trig_o !== 1'b1) begin n_fail++; $display("FAIL single_trig_t1: got %0b want 1", trig_o); end
        step;
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL single_trig_t2: got %0b want 0", trig_o); end
        step; step;
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_t4: got %0b want 0", event_valid_o); end
        step;
        n_checks++; if (event_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid_t5: got %0b want 1", event_valid_o); end
        n_checks++; if (event_beams_o !== 46'h1) begin n_fail++; $display("FAIL single_beams: got %h want 1", event_beams_o); end
        n_checks++; if (event_ts_o !== ts_exp) begin n_fail++; $display("FAIL single_ts: got %0d want %0d", event_ts_o, ts_exp); end
        event_ready_i = 1'b1;
        step;
        event_ready_i = 1'b0;
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got %0b want 0", event_valid_o); end
    endtask

    task automatic test_accum;
        logic [45:0] pat [0:5];
        int pulses;
        pat[0] = 46'h1; pat[1] = '0; pat[2] = 46'h8; pat[3] = '0;
        pat[4] = 46'h1 << 45; pat[5] = '0;
        pulses = 0;
        holdoff_i = 16'd4; ts_exp = ts_model;
        for (int k = 0; k < 6; k++) begin
            trigger_i = pat[k];
            if (k == 1) holdoff_i = 16'd10;
            step;
            if (trig_o === 1'b1) pulses++;
            if (k == 3) begin
                n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL accum_valid_early: got %0b want 0", event_valid_o); end
            end
            if (k == 4) begin
                n_checks++; if (event_valid_o !== 1'b1) begin n_fail++; $display("FAIL accum_valid: got %0b want 1", event_valid_o); end
            end
        end
        trigger_i = '0;
        beams_exp = 46'h1 | 46'h8 | (46'h1 << 45);
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL accum_pulses: got %0d want 1", pulses); end
        n_checks++; if (event_beams_o !== beams_exp) begin n_fail++; $display("FAIL accum_beams: got %h want %h", event_beams_o, beams_exp); end
        n_checks++; if (event_ts_o !== ts_exp) begin n_fail++; $display("FAIL accum_ts: got %0d want %0d", event_ts_o, ts_exp); end
    endtask

    task automatic test_drop;
        logic [31:0] ts_old;
        ts_old = ts_exp;
        mask_i = 46'h2; trigger_i = 46'h2;
        step;
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL masked_trig: got %0b want 0", trig_o); end
        n_checks++; if (drop_count_o !== 16'd0) begin n_fail++; $display("FAIL masked_drop: got %0d want 0", drop_count_o); end
        mask_i = '0; trigger_i = 46'h20;
        for (int k = 0; k < 3; k++) step;
        trigger_i = '0;
        n_checks++; if (drop_count_o !== 16'd3) begin n_fail++; $display("FAIL drop_count: got %0d want 3", drop_count_o); end
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL drop_trig: got %0b want 0", trig_o); end
        n_checks++; if (event_beams_o !== beams_exp) begin n_fail++; $display("FAIL drop_beams_stable: got %h want %h", event_beams_o, beams_exp); end
        n_checks++; if (event_ts_o !== ts_old) begin n_fail++; $display("FAIL drop_ts_stable: got %0d want %0d", event_ts_o, ts_old); end
        event_ready_i = 1'b1; holdoff_i = '0; trigger_i = 46'h80; ts_exp = ts_model;
        step;
        trigger_i = '0;
        n_checks++; if (trig_o !== 1'b1) begin n_fail++; $display("FAIL ready_accept_trig: got %0b want 1", trig_o); end
        n_checks++; if (event_valid_o !== 1'b1) begin n_fail++; $display("FAIL ready_accept_valid: got %0b want 1", event_valid_o); end
        n_checks++; if (event_beams_o !== 46'h80) begin n_fail++; $display("FAIL ready_accept_beams: got %h want 80", event_beams_o); end
        n_checks++; if (event_ts_o !== ts_exp) begin n_fail++; $display("FAIL ready_accept_ts: got %0d want %0d", event_ts_o, ts_exp); end
        n_checks++; if (drop_count_o !== 16'd3) begin n_fail++; $display("FAIL ready_accept_drop: got %0d want 3", drop_count_o); end
    endtask

    task automatic test_back_to_back;
        logic [45:0] b;
        event_ready_i = 1'b1; holdoff_i = '0;
        for (int i = 1; i <= 3; i++) begin
            b = 46'h1 << i;
            trigger_i = b; ts_exp = ts_model;
            step;
            n_checks++; if (trig_o !== 1'b1) begin n_fail++; $display("FAIL b2b_trig%0d: got %0b want 1", i, trig_o); end
            n_checks++; if (event_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %0b want 1", i, event_valid_o); end
            n_checks++; if (event_beams_o !== b) begin n_fail++; $display("FAIL b2b_beams%0d: got %h want %h", i, event_beams_o, b); end
            n_checks++; if (event_ts_o !== ts_exp) begin n_fail++; $display("FAIL b2b_ts%0d: got %0d want %0d", i, event_ts_o, ts_exp); end
        end
        trigger_i = '0; cnt_clr_i = 1'b1;
        step;
        cnt_clr_i = 1'b0;
        n_checks++; if (drop_count_o !== 16'd0) begin n_fail++; $display("FAIL clr_drop: got %0d want 0", drop_count_o); end
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0b want 0", event_valid_o); end
        event_ready_i = 1'b0; trigger_i = 46'h200;
        step;
        cnt_clr_i = 1'b1;
        step;
        trigger_i = '0; cnt_clr_i = 1'b0;
        n_checks++; if (drop_count_o !== 16'd1) begin n_fail++; $display("FAIL clr_with_drop: got %0d want 1", drop_count_o); end
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL clr_with_drop_trig: got %0b want 0", trig_o); end
        event_ready_i = 1'b1;
        step;
        event_ready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        holdoff_i = 16'd4; trigger_i = 46'h1;
        step;
        trigger_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++; if (trig_o !== 1'b0) begin n_fail++; $display("FAIL arst_trig: got %0b want 0", trig_o); end
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", event_valid_o); end
        n_checks++; if (event_beams_o !== '0) begin n_fail++; $display("FAIL arst_beams: got %h want 0", event_beams_o); end
        n_checks++; if (event_ts_o !== '0) begin n_fail++; $display("FAIL arst_ts: got %h want 0", event_ts_o); end
        n_checks++; if (drop_count_o !== '0) begin n_fail++; $display("FAIL arst_drop: got %0d want 0", drop_count_o); end
        step;
        rst_ni = 1'b1; ts_model = 0;
        holdoff_i = 16'd2; trigger_i = 46'h1 << 44; ts_exp = ts_model;
        step;
        trigger_i = '0;
        n_checks++; if (trig_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_trig: got %0b want 1", trig_o); end
        step;
        n_checks++; if (event_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid_early: got %0b want 0", event_valid_o); end
        step;
        n_checks++; if (event_valid_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid: got %0b want 1", event_valid_o); end
        n_checks++; if (event_beams_o !== (46'h1 << 44)) begin n_fail++; $display("FAIL post_rst_beams: got %h want %h", event_beams_o, 46'h1 << 44); end
        n_checks++; if (event_ts_o !== ts_exp) begin n_fail++; $display("FAIL post_rst_ts: got %0d want %0d", event_ts_o, ts_exp); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_accum;
        test_drop;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
